// File: rtl/procb_rd_sched_if.sv
// Consumer-side bus of the procb read scheduler: record stream plus sequence-done report.
interface procb_rd_sched_if #(
    parameter int unsigned N_THREADS     = 16,
    parameter int unsigned PROCB_D_WIDTH = 64
);
    localparam int unsigned TW = $clog2(N_THREADS);

    logic [PROCB_D_WIDTH-1:0] out_data;
    logic [TW-1:0]            out_thread_num;
    logic                     out_valid;
    logic                     out_ready;
    logic                     done;
    logic [TW-1:0]            done_thread;

    modport master (
        output out_data, out_thread_num, out_valid, done, done_thread,
        input  out_ready
    );

    modport slave (
        input  out_data, out_thread_num, out_valid, done, done_thread,
        output out_ready
    );
endinterface

// File: rtl/procb_rd_sched.sv
// Read-side scheduler for the per-thread procb record buffer: round-robin thread grant,
// record streaming to the SHA block former until FIN/STOP, then completion report.
module procb_rd_sched #(
    parameter  int unsigned N_THREADS     = 16,
    parameter  int unsigned PROCB_D_WIDTH = 64,
    localparam int unsigned N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [N_THREADS-1:0]     thread_ready,
    output logic [N_THREADS_MSB:0]   rd_thread_num,
    output logic                     rd_en,
    output logic                     lookup_en,
    output logic                     rd_rst,
    input  logic                     lookup_empty,
    input  logic [PROCB_D_WIDTH-1:0] dout,
    procb_rd_sched_if.master         cons,
    output logic                     err_underflow
);
    localparam int unsigned TW               = N_THREADS_MSB + 1;
    localparam int unsigned FIN_BIT          = PROCB_D_WIDTH - 1;
    localparam int unsigned STOP_BIT         = PROCB_D_WIDTH - 2;
    localparam int unsigned UNDERFLOW_CYCLES = 16;
    localparam int unsigned ECW              = $clog2(UNDERFLOW_CYCLES);
    localparam int unsigned HOLD_CYCLES      = 3;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_STREAM, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 yield_c;
    logic                 settle_q;
    logic [ECW-1:0]       empty_cnt_q;
    logic [TW-1:0]        rr_ptr_q;
    logic [1:0]           hold_cnt_q [N_THREADS];
    logic [N_THREADS-1:0] hold_mask_c;
    logic [N_THREADS-1:0] elig_c;
    logic                 any_elig_c;
    logic [TW-1:0]        grant_c;
    logic                 done_q;
    logic [TW-1:0]        done_thread_q;
    logic                 fin_done_c;

    // Eligibility and round-robin pick, first eligible at or after rr_ptr_q
    always_comb begin
        hold_mask_c = '0;
        for (int i = 0; i < int'(N_THREADS); i++) begin
            hold_mask_c[i] = |hold_cnt_q[i];
        end
        elig_c     = thread_ready & ~hold_mask_c;
        any_elig_c = 1'b0;
        grant_c    = '0;
        for (int i = 0; i < int'(N_THREADS); i++) begin
            if (!any_elig_c && elig_c[(int'(rr_ptr_q) + i) % int'(N_THREADS)]) begin
                any_elig_c = 1'b1;
                grant_c    = TW'((int'(rr_ptr_q) + i) % int'(N_THREADS));
            end
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        yield_c = 1'b0;
        unique case (state_q)
            S_IDLE:   if (any_elig_c) state_d = S_SETTLE;
            S_SETTLE: if (settle_q)   state_d = S_STREAM;
            S_STREAM: begin
                if (!lookup_empty && cons.out_ready && (dout[FIN_BIT] || dout[STOP_BIT])) begin
                    state_d = S_DONE;
                end else if (lookup_empty && empty_cnt_q == ECW'(UNDERFLOW_CYCLES - 1)) begin
                    state_d = S_DONE;
                    yield_c = 1'b1;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Buffer strobes and consumer stream; STOP on the consumed record discards the remainder
    always_comb begin
        cons.out_valid      = (state_q == S_STREAM) && !lookup_empty;
        cons.out_data       = dout;
        cons.out_thread_num = rd_thread_num;
        rd_en               = cons.out_valid && cons.out_ready;
        lookup_en           = rd_en;
        rd_rst              = rd_en && dout[STOP_BIT];
    end

    assign fin_done_c       = (state_q == S_STREAM) && (state_d == S_DONE) && !yield_c;
    assign cons.done        = done_q;
    assign cons.done_thread = done_thread_q;

    // Grant register, settle/underflow counters, completion report, round-robin and hold masks
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_thread_num <= '0;
            rr_ptr_q      <= '0;
            settle_q      <= 1'b0;
            empty_cnt_q   <= '0;
            done_q        <= 1'b0;
            done_thread_q <= '0;
            err_underflow <= 1'b0;
            for (int i = 0; i < int'(N_THREADS); i++) hold_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_THREADS); i++) begin
                if (hold_cnt_q[i] != 2'd0) hold_cnt_q[i] <= hold_cnt_q[i] - 2'd1;
            end
            settle_q <= (state_q == S_SETTLE) && !settle_q;
            if (state_q == S_STREAM && lookup_empty) empty_cnt_q <= empty_cnt_q + ECW'(1);
            else                                     empty_cnt_q <= '0;
            done_q <= fin_done_c;
            if (fin_done_c) done_thread_q <= rd_thread_num;
            if (yield_c)    err_underflow <= 1'b1;
            if (state_q == S_IDLE && any_elig_c) rd_thread_num <= grant_c;
            if (state_q == S_DONE) begin
                rr_ptr_q <= (rd_thread_num == TW'(N_THREADS - 1)) ? '0 : rd_thread_num + TW'(1);
                // Keep the finished thread out of arbitration while its ready status settles
                hold_cnt_q[rd_thread_num] <= 2'(HOLD_CYCLES);
            end
        end
    end
endmodule
